// File: rtl/ipg_rx_parser_pkg.sv
// Shared IPG message definitions: word codes, header field offsets and the message type index.
package ipg_rx_parser_pkg;

  localparam logic [7:0] IPG_CODE_RREQ  = 8'h1A;
  localparam logic [7:0] IPG_CODE_RRESP = 8'h1B;
  localparam logic [7:0] IPG_CODE_WREQ  = 8'h1C;
  localparam logic [7:0] IPG_CODE_LAST  = 8'h1D;

  localparam int unsigned IPG_DST_LSB = 8;
  localparam int unsigned IPG_SRC_LSB = 28;

  // Encoding matches the output scheduler's fire_type_sel.
  typedef enum logic [1:0] {
    TypeRreq  = 2'd0,
    TypeRresp = 2'd1,
    TypeWreq  = 2'd2
  } ipg_type_e;

  function automatic logic is_req_code(input logic [7:0] code);
    return (code == IPG_CODE_RREQ) || (code == IPG_CODE_RRESP) || (code == IPG_CODE_WREQ);
  endfunction

  function automatic ipg_type_e code_to_type(input logic [7:0] code);
    case (code)
      IPG_CODE_RRESP: return TypeRresp;
      IPG_CODE_WREQ:  return TypeWreq;
      default:        return TypeRreq;
    endcase
  endfunction

  function automatic logic [7:0] type_to_code(input ipg_type_e t);
    case (t)
      TypeRresp: return IPG_CODE_RRESP;
      TypeWreq:  return IPG_CODE_WREQ;
      default:   return IPG_CODE_RREQ;
    endcase
  endfunction

endpackage

// File: rtl/ipg_rx_parser_if.sv
// Bundle of the raw RX IPG input and the parsed per-port forwarding outputs.
interface ipg_rx_parser_if #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADR_WIDTH     = 40,
  parameter int unsigned ERR_CNT_WIDTH = 16
);
  logic                     rx_ipg_en;
  logic [DATA_WIDTH-1:0]    rx_ipg_data;
  logic                     iv_ipg_en;
  logic [ADR_WIDTH/2-1:0]   src;
  logic [ADR_WIDTH/2-1:0]   dst;
  logic                     rreq_valid;
  logic                     rresp_valid;
  logic                     wreq_valid;
  logic [DATA_WIDTH-1:0]    fwd_ipg_data;
  logic                     last;
  logic                     abort;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  // Environment side: PHY extractor plus downstream virtual ports.
  modport master (
    output rx_ipg_en, rx_ipg_data,
    input  iv_ipg_en, src, dst, rreq_valid, rresp_valid, wreq_valid, fwd_ipg_data, last, abort,
    input  err_cnt
  );

  // Parser side.
  modport slave (
    input  rx_ipg_en, rx_ipg_data,
    output iv_ipg_en, src, dst, rreq_valid, rresp_valid, wreq_valid, fwd_ipg_data, last, abort,
    output err_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/ipg_rx_parser.sv
// Per-port IPG RX parser: classifies words, latches header src/dst, enforces message framing.
module ipg_rx_parser
  import ipg_rx_parser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADR_WIDTH     = 40,
  parameter int unsigned MAX_MSG_WORDS = 16,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  ipg_rx_parser_if.slave bus
);
  localparam int unsigned HalfW = ADR_WIDTH / 2;
  localparam int unsigned CntW  = $clog2(MAX_MSG_WORDS + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_MSG_WORDS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBody = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]            state_q, state_d;
  ipg_type_e             type_q, type_d;
  logic [CntW-1:0]       word_cnt_q, word_cnt_d;
  logic [HalfW-1:0]      src_q, src_d, dst_q, dst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  iv_en_q, iv_en_d;
  logic [2:0]            valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  abort_q, abort_d;
  logic                  err_inc, take_hdr, fwd;
  logic [7:0]            code;
  logic                  is_req;

  assign code   = bus.rx_ipg_data[7:0];
  assign is_req = is_req_code(code);

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    word_cnt_d = word_cnt_q;
    src_d      = src_q;
    dst_d      = dst_q;
    data_d     = data_q;
    iv_en_d    = 1'b0;
    valid_d    = '0;
    last_d     = 1'b0;
    abort_d    = 1'b0;
    err_inc    = 1'b0;
    take_hdr   = 1'b0;
    fwd        = 1'b0;

    if (bus.rx_ipg_en) begin
      unique case (state_q)
        StIdle: begin
          if (is_req) begin
            take_hdr = 1'b1;
            state_d  = StBody;
          end else begin
            err_inc = 1'b1;
          end
        end
        StBody: begin
          if ((code == type_to_code(type_q)) || (code == IPG_CODE_LAST)) begin
            if (word_cnt_q >= MaxCnt) begin
              abort_d = 1'b1;
              err_inc = 1'b1;
              state_d = (code == IPG_CODE_LAST) ? StIdle : StDrop;
            end else if (code == IPG_CODE_LAST) begin
              fwd        = 1'b1;
              last_d     = 1'b1;
              word_cnt_d = '0;
              state_d    = StIdle;
            end else begin
              fwd        = 1'b1;
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else if (is_req) begin
            // Resync: flush the old message and start a new one with this word.
            abort_d  = 1'b1;
            err_inc  = 1'b1;
            take_hdr = 1'b1;
          end else begin
            abort_d = 1'b1;
            err_inc = 1'b1;
            state_d = StDrop;
          end
        end
        StDrop: begin
          if (code == IPG_CODE_LAST) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (take_hdr) begin
      type_d     = code_to_type(code);
      src_d      = bus.rx_ipg_data[IPG_SRC_LSB +: HalfW];
      dst_d      = bus.rx_ipg_data[IPG_DST_LSB +: HalfW];
      word_cnt_d = CntW'(1);
      fwd        = 1'b1;
    end

    if (fwd) begin
      iv_en_d = 1'b1;
      data_d  = bus.rx_ipg_data;
      valid_d = 3'b001 << type_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      type_q     <= TypeRreq;
      word_cnt_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      iv_en_q    <= 1'b0;
      valid_q    <= '0;
      last_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      word_cnt_q <= word_cnt_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      data_q     <= data_d;
      iv_en_q    <= iv_en_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      abort_q    <= abort_d;
    end
  end

  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  sat_counter #(
    .WIDTH(ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_inc),
    .count(err_cnt)
  );

  assign bus.iv_ipg_en    = iv_en_q;
  assign bus.src          = src_q;
  assign bus.dst          = dst_q;
  assign bus.rreq_valid   = valid_q[TypeRreq];
  assign bus.rresp_valid  = valid_q[TypeRresp];
  assign bus.wreq_valid   = valid_q[TypeWreq];
  assign bus.fwd_ipg_data = data_q;
  assign bus.last         = last_q;
  assign bus.abort        = abort_q;
  assign bus.err_cnt      = err_cnt;
endmodule

// File: tb/tb_ipg_rx_parser.sv
// Directed bench for ipg_rx_parser with MAX_MSG_WORDS=4 so the overflow path is reachable.
module tb_ipg_rx_parser;
  import ipg_rx_parser_pkg::*;

  // Flag order: {iv_ipg_en, rreq_valid, rresp_valid, wreq_valid, last, abort}
  localparam logic [5:0] FNone  = 6'b000000;
  localparam logic [5:0] FRreq  = 6'b110000;
  localparam logic [5:0] FRresp = 6'b101000;
  localparam logic [5:0] FWreq  = 6'b100100;
  localparam logic [5:0] FLast  = 6'b000010;
  localparam logic [5:0] FAbort = 6'b000001;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [63:0] w;
    logic [5:0]  f;
    logic [19:0] s;
    logic [19:0] d;
    logic [15:0] c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ipg_rx_parser_if bus ();

  ipg_rx_parser #(
    .MAX_MSG_WORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [5:0] flags();
    return {bus.iv_ipg_en, bus.rreq_valid, bus.rresp_valid, bus.wreq_valid, bus.last, bus.abort};
  endfunction

  function automatic logic [63:0] hdr(input logic [7:0] code, input logic [19:0] d,
                                      input logic [19:0] s);
    return {16'hBEEF, s, d, code};
  endfunction

  // Non-header words carry junk in [47:8] that must not leak into src/dst.
  function automatic logic [63:0] body(input logic [7:0] code);
    return {56'hC35A_5AA5_A50F_0F, code};
  endfunction

  task automatic step(input logic r, input logic en, input logic [63:0] d);
    rst = r;
    bus.rx_ipg_en = en;
    bus.rx_ipg_data = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, hdr(IPG_CODE_WREQ, 20'h12345, 20'h6789A));
    vectors++;
    if ({flags(), bus.src, bus.dst, bus.err_cnt} !== {FNone, 20'h0, 20'h0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got flags=%b src=%h dst=%h err=%0d, want all zero",
               flags(), bus.src, bus.dst, bus.err_cnt);
    end
    vectors++;
    if (bus.fwd_ipg_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_fwd_data: got %h want 0", bus.fwd_ipg_data);
    end
  endtask

  task automatic test_rreq_msg();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 64'h0, FNone, 20'h0, 20'h0, 16'd0});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RREQ, 20'h2, 20'h0), FRreq, 20'h0, 20'h2, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RREQ), FRreq, 20'h0, 20'h2, 16'd0});
    v.push_back('{1'b0, 1'b0, 64'h0, FNone, 20'h0, 20'h2, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FRreq | FLast, 20'h0, 20'h2, 16'd0});
    v.push_back('{1'b0, 1'b0, 64'h0, FNone, 20'h0, 20'h2, 16'd0});
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rst, v[i].en, v[i].w);
      vectors++;
      if ({flags(), bus.src, bus.dst, bus.err_cnt} !== {v[i].f, v[i].s, v[i].d, v[i].c}) begin
        miscompares++;
        $display("FAIL rreq_msg[%0d]: got flags=%b src=%h dst=%h err=%0d want %b %h %h %0d", i,
                 flags(), bus.src, bus.dst, bus.err_cnt, v[i].f, v[i].s, v[i].d, v[i].c);
      end
      if (v[i].f[5]) begin
        vectors++;
        if (bus.fwd_ipg_data !== v[i].w) begin
          miscompares++;
          $display("FAIL rreq_msg_data[%0d]: got %h want %h", i, bus.fwd_ipg_data, v[i].w);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 64'h0, FNone, 20'h0, 20'h0, 16'd0});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_WREQ, 20'h12345, 20'hABCDE), FWreq,
                  20'hABCDE, 20'h12345, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FWreq | FLast, 20'hABCDE, 20'h12345, 16'd0});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RRESP, 20'h00111, 20'h00222), FRresp,
                  20'h00222, 20'h00111, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RRESP), FRresp, 20'h00222, 20'h00111, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FRresp | FLast, 20'h00222, 20'h00111, 16'd0});
    v.push_back('{1'b0, 1'b0, 64'h0, FNone, 20'h00222, 20'h00111, 16'd0});
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rst, v[i].en, v[i].w);
      vectors++;
      if ({flags(), bus.src, bus.dst, bus.err_cnt} !== {v[i].f, v[i].s, v[i].d, v[i].c}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got flags=%b src=%h dst=%h err=%0d want %b %h %h %0d", i,
                 flags(), bus.src, bus.dst, bus.err_cnt, v[i].f, v[i].s, v[i].d, v[i].c);
      end
      if (v[i].f[5]) begin
        vectors++;
        if (bus.fwd_ipg_data !== v[i].w) begin
          miscompares++;
          $display("FAIL back_to_back_data[%0d]: got %h want %h", i, bus.fwd_ipg_data, v[i].w);
        end
      end
    end
  endtask

  task automatic test_stray_idle();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 64'h0, FNone, 20'h0, 20'h0, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FNone, 20'h0, 20'h0, 16'd1});
    v.push_back('{1'b0, 1'b1, body(8'h55), FNone, 20'h0, 20'h0, 16'd2});
    v.push_back('{1'b0, 1'b0, 64'h0, FNone, 20'h0, 20'h0, 16'd2});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RREQ, 20'h1, 20'h1), FRreq, 20'h1, 20'h1, 16'd2});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FRreq | FLast, 20'h1, 20'h1, 16'd2});
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rst, v[i].en, v[i].w);
      vectors++;
      if ({flags(), bus.src, bus.dst, bus.err_cnt} !== {v[i].f, v[i].s, v[i].d, v[i].c}) begin
        miscompares++;
        $display("FAIL stray_idle[%0d]: got flags=%b src=%h dst=%h err=%0d want %b %h %h %0d", i,
                 flags(), bus.src, bus.dst, bus.err_cnt, v[i].f, v[i].s, v[i].d, v[i].c);
      end
    end
  endtask

  task automatic test_resync();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 64'h0, FNone, 20'h0, 20'h0, 16'd0});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RREQ, 20'h5, 20'h6), FRreq, 20'h6, 20'h5, 16'd0});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_WREQ, 20'h7, 20'h8), FWreq | FAbort,
                  20'h8, 20'h7, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_WREQ), FWreq, 20'h8, 20'h7, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FWreq | FLast, 20'h8, 20'h7, 16'd1});
    v.push_back('{1'b0, 1'b0, 64'h0, FNone, 20'h8, 20'h7, 16'd1});
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rst, v[i].en, v[i].w);
      vectors++;
      if ({flags(), bus.src, bus.dst, bus.err_cnt} !== {v[i].f, v[i].s, v[i].d, v[i].c}) begin
        miscompares++;
        $display("FAIL resync[%0d]: got flags=%b src=%h dst=%h err=%0d want %b %h %h %0d", i,
                 flags(), bus.src, bus.dst, bus.err_cnt, v[i].f, v[i].s, v[i].d, v[i].c);
      end
      if (v[i].f[5]) begin
        vectors++;
        if (bus.fwd_ipg_data !== v[i].w) begin
          miscompares++;
          $display("FAIL resync_data[%0d]: got %h want %h", i, bus.fwd_ipg_data, v[i].w);
        end
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 64'h0, FNone, 20'h0, 20'h0, 16'd0});
    // 6-word rresp message: 4 forwarded, 5th aborts, 6th (last) swallowed by DROP.
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RRESP, 20'h0AAAA, 20'h0BBBB), FRresp,
                  20'h0BBBB, 20'h0AAAA, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RRESP), FRresp, 20'h0BBBB, 20'h0AAAA, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RRESP), FRresp, 20'h0BBBB, 20'h0AAAA, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RRESP), FRresp, 20'h0BBBB, 20'h0AAAA, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RRESP), FAbort, 20'h0BBBB, 20'h0AAAA, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FNone, 20'h0BBBB, 20'h0AAAA, 16'd1});
    // Last word arriving as the 5th: abort and return straight to IDLE.
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RREQ, 20'h1, 20'h2), FRreq, 20'h2, 20'h1, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RREQ), FRreq, 20'h2, 20'h1, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RREQ), FRreq, 20'h2, 20'h1, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RREQ), FRreq, 20'h2, 20'h1, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FAbort, 20'h2, 20'h1, 16'd2});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_WREQ, 20'h3, 20'h4), FWreq, 20'h4, 20'h3, 16'd2});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FWreq | FLast, 20'h4, 20'h3, 16'd2});
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rst, v[i].en, v[i].w);
      vectors++;
      if ({flags(), bus.src, bus.dst, bus.err_cnt} !== {v[i].f, v[i].s, v[i].d, v[i].c}) begin
        miscompares++;
        $display("FAIL overflow[%0d]: got flags=%b src=%h dst=%h err=%0d want %b %h %h %0d", i,
                 flags(), bus.src, bus.dst, bus.err_cnt, v[i].f, v[i].s, v[i].d, v[i].c);
      end
    end
  endtask

  task automatic test_unknown_in_body();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 64'h0, FNone, 20'h0, 20'h0, 16'd0});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_WREQ, 20'h11, 20'h22), FWreq, 20'h22, 20'h11, 16'd0});
    v.push_back('{1'b0, 1'b1, body(8'h77), FAbort, 20'h22, 20'h11, 16'd1});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RREQ, 20'h99, 20'h98), FNone, 20'h22, 20'h11, 16'd1});
    v.push_back('{1'b0, 1'b0, 64'h0, FNone, 20'h22, 20'h11, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FNone, 20'h22, 20'h11, 16'd1});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RRESP, 20'h33, 20'h44), FRresp, 20'h44, 20'h33, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FRresp | FLast, 20'h44, 20'h33, 16'd1});
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rst, v[i].en, v[i].w);
      vectors++;
      if ({flags(), bus.src, bus.dst, bus.err_cnt} !== {v[i].f, v[i].s, v[i].d, v[i].c}) begin
        miscompares++;
        $display("FAIL unknown_body[%0d]: got flags=%b src=%h dst=%h err=%0d want %b %h %h %0d", i,
                 flags(), bus.src, bus.dst, bus.err_cnt, v[i].f, v[i].s, v[i].d, v[i].c);
      end
    end
  endtask

  task automatic test_rst_mid_body();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 64'h0, FNone, 20'h0, 20'h0, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FNone, 20'h0, 20'h0, 16'd1});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RREQ, 20'h3, 20'h4), FRreq, 20'h4, 20'h3, 16'd1});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_RREQ), FRreq, 20'h4, 20'h3, 16'd1});
    v.push_back('{1'b1, 1'b1, body(IPG_CODE_RREQ), FNone, 20'h0, 20'h0, 16'd0});
    v.push_back('{1'b0, 1'b1, hdr(IPG_CODE_RRESP, 20'h9, 20'hA), FRresp, 20'hA, 20'h9, 16'd0});
    v.push_back('{1'b0, 1'b1, body(IPG_CODE_LAST), FRresp | FLast, 20'hA, 20'h9, 16'd0});
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rst, v[i].en, v[i].w);
      vectors++;
      if ({flags(), bus.src, bus.dst, bus.err_cnt} !== {v[i].f, v[i].s, v[i].d, v[i].c}) begin
        miscompares++;
        $display("FAIL rst_mid_body[%0d]: got flags=%b src=%h dst=%h err=%0d want %b %h %h %0d", i,
                 flags(), bus.src, bus.dst, bus.err_cnt, v[i].f, v[i].s, v[i].d, v[i].c);
      end
      if (v[i].rst) begin
        vectors++;
        if (bus.fwd_ipg_data !== 64'h0) begin
          miscompares++;
          $display("FAIL rst_mid_body_data[%0d]: got %h want 0", i, bus.fwd_ipg_data);
        end
      end
    end
  endtask

  initial begin
    bus.rx_ipg_en = 1'b0;
    bus.rx_ipg_data = '0;
    test_reset();
    test_rreq_msg();
    test_back_to_back();
    test_stray_idle();
    test_resync();
    test_overflow();
    test_unknown_in_body();
    test_rst_mid_body();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
